// File: rtl/instruction_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into instruction
// words, writes them to consecutive memory addresses, then verifies an XOR checksum.
module instruction_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   num_words_q;
    logic [ADDR_WIDTH:0]   word_cnt_q;
    logic [BCW-1:0]        byte_cnt_q;
    logic [DATA_WIDTH-1:0] word_buf_q;
    logic [DATA_WIDTH-1:0] word_next;
    logic [7:0]            checksum_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  error_q;
    logic                  byte_fire;
    logic                  last_byte;
    logic                  last_word;

    assign byte_ready = (state_q == RECV) || (state_q == CHECK);
    assign byte_fire  = byte_valid && byte_ready;
    assign last_byte  = (byte_cnt_q == BCW'(BYTES - 1));
    assign last_word  = ((word_cnt_q + (ADDR_WIDTH + 1)'(1)) == num_words_q);

    // Current word with the incoming byte dropped into its lane, so the final
    // byte of a word can be captured straight into wr_data.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        word_next = word_buf_q;
        for (int i = 0; i < BYTES; i++) begin
            if (byte_cnt_q == BCW'(i)) begin
                word_next[8*i +: 8] = byte_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words > CAPACITY) begin
                        state_d = DONE;
                    end else if (num_words == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV:  if (byte_fire && last_byte) state_d = WRITE;
            WRITE: state_d = last_word ? CHECK : RECV;
            CHECK: if (byte_fire) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_words_q <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            word_buf_q  <= '0;
            checksum_q  <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            error_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        num_words_q <= num_words;
                        word_cnt_q  <= '0;
                        byte_cnt_q  <= '0;
                        word_buf_q  <= '0;
                        checksum_q  <= '0;
                        error_q     <= (num_words > CAPACITY);
                    end
                end
                RECV: begin
                    if (byte_fire) begin
                        word_buf_q <= word_next;
                        checksum_q <= checksum_q ^ byte_data;
                        if (last_byte) begin
                            byte_cnt_q <= '0;
                            wr_data_q  <= word_next;
                            wr_addr_q  <= word_cnt_q[ADDR_WIDTH-1:0];
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCW'(1);
                        end
                    end
                end
                WRITE: begin
                    word_cnt_q <= word_cnt_q + (ADDR_WIDTH + 1)'(1);
                end
                CHECK: begin
                    if (byte_fire && (byte_data != checksum_q)) begin
                        error_q <= 1'b1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    // Write address/data are registered so they hold after the strobe drops.
    assign wr_en    = (state_q == WRITE);
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != IDLE);
    assign cpu_hold = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign error    = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: randomized word streams checked against
// a queue-based reference of expected writes and the stream's XOR checksum.
module tb_instruction_loader;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 12;
    localparam int BYTES      = DATA_WIDTH / 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [ADDR_WIDTH:0]   num_words;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;
    logic                  error;

    instruction_loader #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: the words to be loaded, in order; word i belongs at address i.
    logic [DATA_WIDTH-1:0] exp_data[$];
    logic [ADDR_WIDTH-1:0] got_addr[$];
    logic [DATA_WIDTH-1:0] got_data[$];
    int   done_cnt;
    logic err_at_done;
    int   rdy_in_write;
    int   rdy_cnt;

    logic busy_after_start, err_after_start, hold_after, busy_after;

    always @(negedge clk) begin
        if (wr_en) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            if (byte_ready) rdy_in_write++;
        end
        if (byte_ready) rdy_cnt++;
        if (done) begin
            done_cnt++;
            err_at_done = error;
        end
    end

    function automatic int write_errors();
        int e = 0;
        if (got_data.size() != exp_data.size()) e++;
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            if (got_addr[i] !== ADDR_WIDTH'(i) || got_data[i] !== exp_data[i]) e++;
        end
        return e;
    endfunction

    // Drives one complete load of exp_data followed by its checksum byte.
    task automatic run_load(input bit bad, input bit toggle, input bit extra_start);
        logic [7:0] stream[$];
        logic [7:0] cs;
        int idx, cyc, limit, n;
        bit acc;
        n = exp_data.size();
        cs = 8'h00; idx = 0; cyc = 0; limit = n * 12 + 40;
        got_addr.delete(); got_data.delete();
        done_cnt = 0; rdy_in_write = 0; err_at_done = 1'bx;
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < BYTES; b++) begin
                stream.push_back(exp_data[w][8*b +: 8]);
                cs ^= exp_data[w][8*b +: 8];
            end
        end
        stream.push_back(bad ? (cs ^ 8'h01) : cs);
        num_words = (ADDR_WIDTH + 1)'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_after_start = busy && cpu_hold;
        err_after_start  = error;
        while (done_cnt == 0 && cyc < limit) begin
            start = extra_start && (cyc == 3);
            if (start) num_words = (ADDR_WIDTH + 1)'(n + 5);
            byte_valid = (idx < stream.size()) && (!toggle || (cyc % 2 == 0));
            byte_data  = (idx < stream.size()) ? stream[idx] : 8'h00;
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        start = 1'b0;
        byte_valid = 1'b0;
        hold_after = cpu_hold;
        busy_after = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({byte_ready, wr_en, cpu_hold, busy, done, error} !== 6'b0)
            $display("FAIL reset_ctrl: got %b need 000000", {byte_ready, wr_en, cpu_hold, busy, done, error});
        else passed++;
        checks++;
        if (wr_addr !== '0 || wr_data !== '0)
            $display("FAIL reset_wr: got addr %h data %h need 0/0", wr_addr, wr_data);
        else passed++;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b need 0", busy);
        else passed++;
    endtask

    task automatic test_basic();
        exp_data.delete();
        exp_data.push_back(32'h0000_0013);
        exp_data.push_back(32'h0010_0093);
        // Stream XOR of 13 00 00 00 93 00 10 00 is 0x90.
        run_load(1'b0, 1'b0, 1'b0);
        checks++;
        if (busy_after_start !== 1'b1) $display("FAIL basic_start: busy&hold got %b need 1", busy_after_start);
        else passed++;
        checks++;
        if (write_errors() !== 0)
            $display("FAIL basic_writes: %0d mismatches, got %0d writes need %0d", write_errors(), got_data.size(), exp_data.size());
        else passed++;
        checks++;
        if (done_cnt !== 1 || err_at_done !== 1'b0)
            $display("FAIL basic_done: done %0d err %b need 1/0", done_cnt, err_at_done);
        else passed++;
        checks++;
        if (hold_after !== 1'b0 || busy_after !== 1'b0)
            $display("FAIL basic_release: hold %b busy %b need 0/0", hold_after, busy_after);
        else passed++;
    endtask

    task automatic test_bad_checksum();
        exp_data.delete();
        exp_data.push_back(32'h0000_0013);
        exp_data.push_back(32'h0010_0093);
        run_load(1'b1, 1'b0, 1'b0);
        checks++;
        if (write_errors() !== 0)
            $display("FAIL bad_writes: %0d mismatches, got %0d writes need %0d", write_errors(), got_data.size(), exp_data.size());
        else passed++;
        checks++;
        if (done_cnt !== 1 || err_at_done !== 1'b1)
            $display("FAIL bad_done: done %0d err %b need 1/1", done_cnt, err_at_done);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (error !== 1'b1) $display("FAIL bad_sticky: error got %b need 1", error);
        else passed++;
    endtask

    task automatic test_zero_words();
        exp_data.delete();
        run_load(1'b0, 1'b0, 1'b0);
        checks++;
        if (err_after_start !== 1'b0) $display("FAIL error_clear: got %b need 0", err_after_start);
        else passed++;
        checks++;
        if (got_data.size() !== 0) $display("FAIL zero_writes: got %0d need 0", got_data.size());
        else passed++;
        checks++;
        if (done_cnt !== 1 || err_at_done !== 1'b0)
            $display("FAIL zero_done: done %0d err %b need 1/0", done_cnt, err_at_done);
        else passed++;
    endtask

    task automatic test_backpressure();
        exp_data.delete();
        for (int i = 0; i < 3; i++) exp_data.push_back($urandom);
        run_load(1'b0, 1'b1, 1'b0);
        checks++;
        if (write_errors() !== 0)
            $display("FAIL bp_writes: %0d mismatches, got %0d writes need %0d", write_errors(), got_data.size(), exp_data.size());
        else passed++;
        checks++;
        if (rdy_in_write !== 0) $display("FAIL bp_ready_in_write: got %0d need 0", rdy_in_write);
        else passed++;
        checks++;
        if (done_cnt !== 1 || err_at_done !== 1'b0)
            $display("FAIL bp_done: done %0d err %b need 1/0", done_cnt, err_at_done);
        else passed++;
    endtask

    task automatic test_oversize();
        got_addr.delete(); got_data.delete();
        done_cnt = 0; rdy_cnt = 0;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        num_words  = 13'd4097;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || error !== 1'b1)
            $display("FAIL over_done: done %b error %b need 1/1", done, error);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b1)
            $display("FAIL over_after: done %b busy %b error %b need 0/0/1", done, busy, error);
        else passed++;
        byte_valid = 1'b0;
        checks++;
        if (got_data.size() !== 0 || rdy_cnt !== 0)
            $display("FAIL over_quiet: writes %0d ready %0d need 0/0", got_data.size(), rdy_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid_word();
        int idx, cyc;
        bit acc;
        exp_data.delete();
        for (int i = 0; i < 2; i++) exp_data.push_back($urandom);
        got_addr.delete(); got_data.delete();
        done_cnt = 0;
        num_words = 13'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; cyc = 0;
        byte_valid = 1'b1;
        while (idx < BYTES + 2 && cyc < 40) begin
            byte_data = exp_data[idx / BYTES][8*(idx % BYTES) +: 8];
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        byte_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({byte_ready, wr_en, cpu_hold, busy, done, error} !== 6'b0 || wr_addr !== '0 || wr_data !== '0)
            $display("FAIL midreset_outputs: ctrl %b addr %h data %h need all 0",
                     {byte_ready, wr_en, cpu_hold, busy, done, error}, wr_addr, wr_data);
        else passed++;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (got_data.size() !== 1 || done_cnt !== 0)
            $display("FAIL midreset_partial: writes %0d done %0d need 1/0", got_data.size(), done_cnt);
        else passed++;
        exp_data.delete();
        for (int i = 0; i < 2; i++) exp_data.push_back($urandom);
        run_load(1'b0, 1'b0, 1'b0);
        checks++;
        if (write_errors() !== 0 || done_cnt !== 1 || err_at_done !== 1'b0)
            $display("FAIL midreset_reload: %0d mismatches done %0d err %b need 0/1/0", write_errors(), done_cnt, err_at_done);
        else passed++;
    endtask

    task automatic test_start_busy();
        exp_data.delete();
        for (int i = 0; i < 2; i++) exp_data.push_back($urandom);
        run_load(1'b0, 1'b0, 1'b1);
        checks++;
        if (write_errors() !== 0)
            $display("FAIL busy_start_writes: %0d mismatches, got %0d writes need %0d", write_errors(), got_data.size(), exp_data.size());
        else passed++;
        checks++;
        if (done_cnt !== 1 || err_at_done !== 1'b0)
            $display("FAIL busy_start_done: done %0d err %b need 1/0", done_cnt, err_at_done);
        else passed++;
    endtask

    task automatic test_random();
        bit bad, toggle;
        for (int t = 0; t < 6; t++) begin
            exp_data.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) exp_data.push_back($urandom);
            bad    = 1'($urandom_range(0, 1));
            toggle = 1'($urandom_range(0, 1));
            run_load(bad, toggle, 1'b0);
            checks++;
            if (write_errors() !== 0 || done_cnt !== 1 || err_at_done !== bad)
                $display("FAIL random_%0d: %0d mismatches done %0d err %b need 0/1/%b", t, write_errors(), done_cnt, err_at_done, bad);
            else passed++;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_full_capacity();
        exp_data.delete();
        for (int i = 0; i < (1 << ADDR_WIDTH); i++) exp_data.push_back($urandom);
        run_load(1'b0, 1'b0, 1'b0);
        checks++;
        if (write_errors() !== 0)
            $display("FAIL full_writes: %0d mismatches, got %0d writes need %0d", write_errors(), got_data.size(), exp_data.size());
        else passed++;
        checks++;
        if (done_cnt !== 1 || err_at_done !== 1'b0)
            $display("FAIL full_done: done %0d err %b need 1/0", done_cnt, err_at_done);
        else passed++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_words = '0;
        byte_valid = 1'b0; byte_data = 8'h00;
        done_cnt = 0; rdy_in_write = 0; rdy_cnt = 0; err_at_done = 1'b0;
        test_reset();
        test_basic();
        test_bad_checksum();
        test_zero_words();
        test_backpressure();
        test_oversize();
        test_reset_mid_word();
        test_start_busy();
        test_random();
        test_full_capacity();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
